// File: rtl/chip8_draw_seq.sv
// CHIP-8 DXYN sprite draw / 00E0 clear sequencer: fetches sprite bytes and
// read-modify-writes framebuffer rows, accumulating VF collision across all rows.
module chip8_draw_seq #(
   parameter int ADDR_W = 12,
   parameter int COLS   = 64,
   parameter int ROWS   = 32
) (
   input  logic                      instruction_clk,
   input  logic                      rst,
   input  logic                      draw_start,
   input  logic                      clear_start,
   input  logic [5:0]                draw_x,
   input  logic [4:0]                draw_y,
   input  logic [3:0]                draw_n,
   input  logic [ADDR_W-1:0]         draw_addr,
   output logic                      busy,
   output logic                      done,
   output logic                      collision,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [7:0]                mem_rdata,
   output logic                      fb_rd_en,
   output logic [$clog2(ROWS)-1:0]   fb_row,
   input  logic [COLS-1:0]           fb_rdata,
   output logic                      fb_wr_en,
   output logic [COLS-1:0]           fb_wr_data
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MERGE, S_CLEAR, S_DONE} state_t;

   state_t            state, state_nx;
   logic [5:0]        x_q;
   logic [4:0]        y_q;
   logic [3:0]        n_q;
   logic [3:0]        k_q;
   logic [ADDR_W-1:0] addr_q;
   logic [RW-1:0]     clr_row;
   logic              acc;
   logic              coll_q;
   logic [COLS-1:0]   mask;
   logic [RW-1:0]     draw_row;
   logic              hit;

   // Sprite bit 7-j lands on column (x+j) mod COLS, giving horizontal wrap.
   always_comb begin
      mask = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         mask[CW'((32'(x_q) + j) % COLS)] = mem_rdata[3'(7 - j)];
      end
   end

   assign draw_row = RW'((32'(y_q) + 32'(k_q)) % ROWS);
   assign hit      = |(fb_rdata & mask);

   always_ff @(posedge instruction_clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      busy       = 1'b0;
      done       = 1'b0;
      collision  = coll_q;
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
      fb_rd_en   = 1'b0;
      fb_row     = '0;
      fb_wr_en   = 1'b0;
      fb_wr_data = '0;
      case (state)
         S_IDLE: begin
            if (clear_start)     state_nx = S_CLEAR;
            else if (draw_start) state_nx = (draw_n != 4'd0) ? S_FETCH : S_DONE;
         end
         S_FETCH: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = addr_q + ADDR_W'(k_q);
            fb_rd_en  = 1'b1;
            fb_row    = draw_row;
            state_nx  = S_MERGE;
         end
         S_MERGE: begin
            busy       = 1'b1;
            fb_wr_en   = 1'b1;
            fb_row     = draw_row;
            fb_wr_data = fb_rdata ^ mask;
            state_nx   = (4'(k_q + 4'd1) == n_q) ? S_DONE : S_FETCH;
         end
         S_CLEAR: begin
            busy     = 1'b1;
            fb_wr_en = 1'b1;
            fb_row   = clr_row;
            if (clr_row == RW'(ROWS - 1)) state_nx = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            collision = acc;
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // Reset aborts in its own cycle: no strobe may escape while rst is high.
      if (rst) begin
         busy       = 1'b0;
         done       = 1'b0;
         collision  = 1'b0;
         mem_rd_en  = 1'b0;
         mem_addr   = '0;
         fb_rd_en   = 1'b0;
         fb_row     = '0;
         fb_wr_en   = 1'b0;
         fb_wr_data = '0;
      end
   end

   always_ff @(posedge instruction_clk) begin
      if (rst) begin
         x_q     <= '0;
         y_q     <= '0;
         n_q     <= '0;
         k_q     <= '0;
         addr_q  <= '0;
         clr_row <= '0;
         acc     <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (clear_start) begin
                  clr_row <= '0;
                  acc     <= 1'b0;
                  coll_q  <= 1'b0;
               end else if (draw_start) begin
                  x_q    <= draw_x;
                  y_q    <= draw_y;
                  n_q    <= draw_n;
                  addr_q <= draw_addr;
                  k_q    <= '0;
                  acc    <= 1'b0;
                  coll_q <= 1'b0;
               end
            end
            S_MERGE: begin
               acc <= acc | hit;
               k_q <= k_q + 4'd1;
            end
            S_CLEAR: clr_row <= clr_row + RW'(1);
            S_DONE:  coll_q  <= acc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_draw_seq.sv
// Directed bench for chip8_draw_seq with behavioural memory and framebuffer
// models; expected rows, cycles and collision values are hand-computed.
module tb_chip8_draw_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        draw_start, clear_start;
   logic [5:0]  draw_x;
   logic [4:0]  draw_y;
   logic [3:0]  draw_n;
   logic [11:0] draw_addr;
   logic        busy, done, collision;
   logic        mem_rd_en;
   logic [11:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        fb_rd_en;
   logic [4:0]  fb_row;
   logic [63:0] fb_rdata;
   logic        fb_wr_en;
   logic [63:0] fb_wr_data;

   bit [7:0]    mem [4096];
   bit [63:0]   fb  [32];
   logic        pre_en;
   logic [4:0]  pre_row;
   logic [63:0] pre_val;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   chip8_draw_seq #(.ADDR_W(12), .COLS(64), .ROWS(32)) dut (
      .instruction_clk(clk),
      .rst(rst),
      .draw_start(draw_start),
      .clear_start(clear_start),
      .draw_x(draw_x),
      .draw_y(draw_y),
      .draw_n(draw_n),
      .draw_addr(draw_addr),
      .busy(busy),
      .done(done),
      .collision(collision),
      .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .fb_rd_en(fb_rd_en),
      .fb_row(fb_row),
      .fb_rdata(fb_rdata),
      .fb_wr_en(fb_wr_en),
      .fb_wr_data(fb_wr_data)
   );

   // Synchronous memory and framebuffer: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
      if (fb_rd_en)  fb_rdata  <= fb[fb_row];
      if (fb_wr_en)    fb[fb_row]  <= fb_wr_data;
      else if (pre_en) fb[pre_row] <= pre_val;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic clr, input logic drw, input logic [5:0] x,
                         input logic [4:0] y, input logic [3:0] n, input logic [11:0] a,
                         output int done_cyc, output int nwr, output int bad_busy,
                         output int bad_strobe, output int bad_wr, output logic coll);
      logic [4:0] er;
      int         ec;
      done_cyc = -1; nwr = 0; bad_busy = 0; bad_strobe = 0; bad_wr = 0; coll = 1'bx;
      @(negedge clk);
      clear_start = clr; draw_start = drw;
      draw_x = x; draw_y = y; draw_n = n; draw_addr = a;
      @(negedge clk);
      clear_start = 1'b0; draw_start = 1'b0;
      draw_x = ~x; draw_y = ~y; draw_n = ~n; draw_addr = ~a;
      for (int c = 1; c <= 80; c++) begin
         if (c > 1) @(negedge clk);
         if (!busy) bad_busy++;
         if (fb_wr_en && (fb_rd_en || mem_rd_en)) bad_strobe++;
         if (done && (fb_wr_en || fb_rd_en || mem_rd_en)) bad_strobe++;
         if (mem_rd_en != fb_rd_en) bad_strobe++;
         if (clr && (mem_rd_en || fb_rd_en)) bad_strobe++;
         if (mem_rd_en) begin
            if ((c % 2) != 1 || mem_addr != 12'(a + 12'((c - 1) / 2)) ||
                fb_row != 5'(y + 5'((c - 1) / 2)))
               bad_strobe++;
         end
         if (fb_wr_en) begin
            er = clr ? 5'(nwr) : 5'(y + 5'(nwr));
            ec = clr ? nwr + 1 : 2 * nwr + 2;
            if (fb_row != er || c != ec || (clr && fb_wr_data != 64'd0)) bad_wr++;
            nwr++;
         end
         if (done) begin
            done_cyc = c;
            coll = collision;
            break;
         end
      end
      @(negedge clk);
      if (busy || done || collision !== coll) bad_busy++;
   endtask

   typedef struct {
      logic        clr, drw;
      logic [5:0]  x;
      logic [4:0]  y;
      logic [3:0]  n;
      logic [11:0] a;
      logic        pre;
      logic [4:0]  prow;
      logic [63:0] pval;
      int          ecyc, ewr;
      logic        ecoll;
      logic [4:0]  ra;
      logic [63:0] va;
      logic [4:0]  rb;
      logic [63:0] vb;
   } vec_t;

   vec_t vec [7];

   initial begin
      int   dc, nw, bb, bs, bw, nrst;
      logic cl;

      vec[0] = '{1'b0, 1'b1, 6'd0,  5'd0,  4'd1, 12'h050, 1'b0, 5'd0, 64'd0,     3,  1, 1'b0, 5'd0,  64'h0000_0000_0000_000F, 5'd1,  64'd0};
      vec[1] = '{1'b0, 1'b1, 6'd0,  5'd0,  4'd1, 12'h050, 1'b0, 5'd0, 64'd0,     3,  1, 1'b1, 5'd0,  64'd0,                    5'd1,  64'd0};
      vec[2] = '{1'b0, 1'b1, 6'd60, 5'd31, 4'd2, 12'h100, 1'b0, 5'd0, 64'd0,     5,  2, 1'b0, 5'd31, 64'hF000_0000_0000_000F, 5'd0,  64'h1000_0000_0000_0008};
      vec[3] = '{1'b0, 1'b1, 6'd8,  5'd4,  4'd5, 12'h200, 1'b1, 5'd4, 64'h100,   11, 5, 1'b1, 5'd4,  64'd0,                    5'd8,  64'h1000};
      vec[4] = '{1'b0, 1'b1, 6'd5,  5'd5,  4'd0, 12'h050, 1'b0, 5'd0, 64'd0,     1,  0, 1'b0, 5'd5,  64'h200,                  5'd4,  64'd0};
      vec[5] = '{1'b1, 1'b1, 6'd0,  5'd0,  4'd1, 12'h050, 1'b0, 5'd0, 64'd0,     33, 32, 1'b0, 5'd8, 64'd0,                    5'd31, 64'd0};
      vec[6] = '{1'b0, 1'b1, 6'd0,  5'd10, 4'd2, 12'hFFF, 1'b0, 5'd0, 64'd0,     5,  2, 1'b0, 5'd10, 64'h80,                   5'd11, 64'h1};

      mem[12'h050] = 8'hF0;
      mem[12'h100] = 8'hFF; mem[12'h101] = 8'h81;
      mem[12'h200] = 8'h80; mem[12'h201] = 8'h40; mem[12'h202] = 8'h20;
      mem[12'h203] = 8'h10; mem[12'h204] = 8'h08;
      mem[12'hFFF] = 8'h01; mem[12'h000] = 8'h80;
      for (int i = 0; i < 4; i++) mem[12'h300 + i] = 8'hFF;

      rst = 1'b1; draw_start = 1'b0; clear_start = 1'b0;
      draw_x = '0; draw_y = '0; draw_n = '0; draw_addr = '0;
      pre_en = 1'b0; pre_row = '0; pre_val = '0;

      repeat (3) @(negedge clk);
      check("reset_ctrl", 64'({busy, done, collision, mem_rd_en, fb_rd_en, fb_wr_en}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ctrl", 64'({busy, done, collision, mem_rd_en, fb_rd_en, fb_wr_en}), 64'd0);
      check("idle_addr", 64'({mem_addr, fb_row}), 64'd0);

      for (int i = 0; i < 7; i++) begin
         if (vec[i].pre) begin
            @(negedge clk);
            pre_row = vec[i].prow; pre_val = vec[i].pval; pre_en = 1'b1;
            @(negedge clk);
            pre_en = 1'b0;
         end
         run_op(vec[i].clr, vec[i].drw, vec[i].x, vec[i].y, vec[i].n, vec[i].a,
                dc, nw, bb, bs, bw, cl);
         check($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(vec[i].ecyc));
         check($sformatf("v%0d_writes", i), 64'(nw), 64'(vec[i].ewr));
         check($sformatf("v%0d_collision", i), 64'(cl), 64'(vec[i].ecoll));
         check($sformatf("v%0d_busy", i), 64'(bb), 64'd0);
         check($sformatf("v%0d_strobes", i), 64'(bs), 64'd0);
         check($sformatf("v%0d_write_order", i), 64'(bw), 64'd0);
         check($sformatf("v%0d_row%0d", i, vec[i].ra), fb[vec[i].ra], vec[i].va);
         check($sformatf("v%0d_row%0d", i, vec[i].rb), fb[vec[i].rb], vec[i].vb);
      end

      // Reset during the FETCH of row 2 of an n=4 draw.
      nw = 0; nrst = 0;
      @(negedge clk);
      draw_start = 1'b1; draw_x = 6'd0; draw_y = 5'd20; draw_n = 4'd4; draw_addr = 12'h300;
      @(negedge clk);
      draw_start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) @(negedge clk);
         if (fb_wr_en) nw++;
      end
      @(negedge clk);
      check("rst_pre_fetch_row", 64'({fb_rd_en, fb_row}), 64'({1'b1, 5'd22}));
      rst = 1'b1;
      #1;
      check("rst_cycle_ctrl", 64'({busy, done, fb_rd_en, fb_wr_en, mem_rd_en}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (busy || done || fb_wr_en || fb_rd_en || mem_rd_en) nrst++;
         @(negedge clk);
      end
      check("rst_writes_before", 64'(nw), 64'd2);
      check("rst_quiet_after", 64'(nrst), 64'd0);
      check("rst_row20", fb[20], 64'hFF);
      check("rst_row21", fb[21], 64'hFF);
      check("rst_row22_untouched", fb[22], 64'd0);

      run_op(1'b0, 1'b1, 6'd0, 5'd22, 4'd1, 12'h300, dc, nw, bb, bs, bw, cl);
      check("post_rst_done_cycle", 64'(dc), 64'd3);
      check("post_rst_collision", 64'(cl), 64'd0);
      check("post_rst_row22", fb[22], 64'hFF);
      check("post_rst_strobes", 64'(bs + bb + bw), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
